// File: rtl/mm_game_ctrl.sv
// Mastermind turn sequencer: secret code generation, guess validation, feedback wait, win/loss.
// Feedback sampled FB_LAT+1 cycles after an accepted submit; submit is ignored outside GUESS (no stall).
module mm_game_ctrl #(
    parameter int          MAX_TURNS  = 8,
    parameter int          NUM_COLORS = 6,
    parameter int          FB_LAT     = 1,
    parameter logic [11:0] SEED       = 12'hACE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       submit,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    input  logic       fb_game_over,
    output logic [2:0] code0,
    output logic [2:0] code1,
    output logic [2:0] code2,
    output logic [2:0] code3,
    output logic [2:0] history0,
    output logic [2:0] history1,
    output logic [2:0] history2,
    output logic [2:0] history3,
    output logic       last_turn,
    output logic [3:0] turn,
    output logic       fb_valid,
    output logic       guess_err,
    output logic       won,
    output logic       lost,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, GEN, GUESS, EVAL, WIN, LOSE} state_t;

    localparam logic [3:0]  NC        = 4'(NUM_COLORS);
    localparam logic [3:0]  LAST_TURN = 4'(MAX_TURNS - 1);
    localparam logic [2:0]  FB_LAT_C  = 3'(FB_LAT);
    localparam logic [11:0] SEED_C    = (SEED == 12'h000) ? 12'h001 : SEED;

    state_t      state, state_nxt;
    logic [11:0] lfsr;
    logic [2:0]  wait_cnt;
    logic        guess_ok;
    logic        fb_sample;
    logic        accept;

    function automatic logic legal(input logic [2:0] d);
        return {1'b0, d} < NC;
    endfunction

    // Raw 3-bit LFSR slices can exceed the colour range; fold them back once.
    function automatic logic [2:0] fold(input logic [2:0] d);
        if ({1'b0, d} >= NC)
            return d - NC[2:0];
        return d;
    endfunction

    assign guess_ok  = legal(guess0) && legal(guess1) && legal(guess2) && legal(guess3);
    assign fb_sample = (state == EVAL) && (wait_cnt == FB_LAT_C);
    assign accept    = (state == GUESS) && submit && !new_game && guess_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = GEN;
        end else begin
            case (state)
                GEN:     state_nxt = GUESS;
                GUESS:   if (submit && guess_ok) state_nxt = EVAL;
                EVAL: begin
                    if (fb_sample) begin
                        if (fb_game_over)
                            state_nxt = WIN;
                        else if (turn == LAST_TURN)
                            state_nxt = LOSE;
                        else
                            state_nxt = GUESS;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        won       = (state == WIN);
        lost      = (state == LOSE);
        busy      = (state == GEN) || (state == EVAL);
        last_turn = ((state == GUESS) || (state == EVAL)) && (turn == LAST_TURN);
        fb_valid  = fb_sample && !new_game;
        guess_err = (state == GUESS) && submit && !new_game && !guess_ok;
    end

    // Datapath: free-running LFSR, feedback wait counter, code/history/turn registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= SEED_C;
            wait_cnt <= 3'd0;
            code0    <= 3'd0;
            code1    <= 3'd0;
            code2    <= 3'd0;
            code3    <= 3'd0;
            history0 <= 3'd0;
            history1 <= 3'd0;
            history2 <= 3'd0;
            history3 <= 3'd0;
            turn     <= 4'd0;
        end else begin
            lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};

            if (accept)
                wait_cnt <= 3'd0;
            else if (state == EVAL)
                wait_cnt <= wait_cnt + 3'd1;

            if (state == GEN && !new_game) begin
                code0    <= fold(lfsr[2:0]);
                code1    <= fold(lfsr[5:3]);
                code2    <= fold(lfsr[8:6]);
                code3    <= fold(lfsr[11:9]);
                history0 <= 3'd0;
                history1 <= 3'd0;
                history2 <= 3'd0;
                history3 <= 3'd0;
                turn     <= 4'd0;
            end else if (accept) begin
                history0 <= guess0;
                history1 <= guess1;
                history2 <= guess2;
                history3 <= guess3;
            end

            if (fb_valid && !fb_game_over && turn != LAST_TURN)
                turn <= turn + 4'd1;
        end
    end

endmodule

// File: tb/tb_mm_game_ctrl.sv
// Directed vector bench for mm_game_ctrl with an LFSR reference and a one-cycle feedback model.
module tb_mm_game_ctrl;

    localparam int          NC    = 6;
    localparam logic [11:0] LEGAL = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [11:0] BAD   = {3'd6, 3'd3, 3'd2, 3'd1};

    logic       clk = 1'b0;
    logic       rst, new_game, submit, fb_game_over;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic [2:0] code0, code1, code2, code3;
    logic [2:0] history0, history1, history2, history3;
    logic       last_turn, fb_valid, guess_err, won, lost, busy;
    logic [3:0] turn;

    mm_game_ctrl #(
        .MAX_TURNS(8), .NUM_COLORS(NC), .FB_LAT(1), .SEED(12'hACE)
    ) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .submit(submit),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .fb_game_over(fb_game_over),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .history0(history0), .history1(history1), .history2(history2), .history3(history3),
        .last_turn(last_turn), .turn(turn), .fb_valid(fb_valid), .guess_err(guess_err),
        .won(won), .lost(lost), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [11:0] code_p, hist_p;
    assign code_p = {code3, code2, code1, code0};
    assign hist_p = {history3, history2, history1, history0};

    // Reference LFSR (taps 12,11,10,4) and a feedback block with one cycle of latency.
    logic [11:0] mdl_lfsr;
    logic        fb_go;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_lfsr <= 12'hACE;
            fb_go    <= 1'b0;
        end else begin
            mdl_lfsr <= {mdl_lfsr[10:0], mdl_lfsr[11] ^ mdl_lfsr[10] ^ mdl_lfsr[9] ^ mdl_lfsr[3]};
            fb_go    <= (hist_p == code_p);
        end
    end
    assign fb_game_over = fb_go;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_code = 12'h000;
    logic [11:0] wrong_p  = 12'h000;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic capture();
        logic [2:0] d;
        for (int i = 0; i < 4; i++) begin
            d = mdl_lfsr[3*i +: 3];
            if (d >= 3'(NC)) d = d - 3'(NC);
            exp_code[3*i +: 3] = d;
        end
        wrong_p = exp_code;
        d = exp_code[2:0] + 3'd1;
        if (d >= 3'(NC)) d = d - 3'(NC);
        wrong_p[2:0] = d;
    endtask

    task automatic drive(input logic ng, input logic sub, input logic [11:0] g);
        new_game = ng;
        submit   = sub;
        guess0   = g[2:0];
        guess1   = g[5:3];
        guess2   = g[8:6];
        guess3   = g[11:9];
    endtask

    // gm: 0 literal guess, 1 secret code, 2 wrong guess. hm: 0 skip, 1 zero, 2 code, 3 wrong guess.
    typedef struct {
        logic       ng, sub;
        logic [1:0] gm;
        logic [11:0] glit;
        logic       cap, cc;
        logic       busy, gerr, fbv, won, lost, last;
        logic [3:0] turn;
        logic [1:0] hm;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic ng, input logic sub, input logic [1:0] gm, input logic [11:0] glit,
                       input logic cap, input logic cc, input logic b, input logic ge, input logic fv,
                       input logic w, input logic l, input logic lt, input logic [3:0] t,
                       input logic [1:0] hm);
        vec_t v;
        v.ng = ng; v.sub = sub; v.gm = gm; v.glit = glit; v.cap = cap; v.cc = cc;
        v.busy = b; v.gerr = ge; v.fbv = fv; v.won = w; v.lost = l; v.last = lt;
        v.turn = t; v.hm = hm;
        vecs.push_back(v);
    endtask

    initial begin
        logic [11:0] g;
        logic [11:0] eh;
        string       tag;

        rst = 1'b0;
        drive(1'b0, 1'b0, 12'h000);
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_won_lost", {won, lost}, 0);
        chk("rst_pulses", {fb_valid, guess_err, last_turn}, 0);
        chk("rst_turn", turn, 0);
        chk("rst_code", code_p, 0);
        chk("rst_hist", hist_p, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        //  ng sub gm glit  cap cc busy gerr fbv won lost last turn hm
        add(0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // IDLE
        add(0, 1, 0, LEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // submit ignored in IDLE
        add(1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0, 0, 0, 1);  // GEN
        add(0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 1);  // GUESS
        add(0, 1, 0, BAD,   0, 0, 0, 1, 0, 0, 0, 0, 0, 1);  // illegal guess
        add(0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // correct guess
        add(0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0, 2);  // EVAL cnt 0
        add(0, 0, 0, 0,     0, 0, 1, 0, 1, 0, 0, 0, 0, 2);  // EVAL cnt 1, fb_valid
        add(0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0, 0, 2);  // WIN
        add(0, 1, 0, BAD,   0, 0, 0, 0, 0, 1, 0, 0, 0, 2);  // submit ignored in WIN
        add(0, 0, 0, 0,     0, 1, 0, 0, 0, 1, 0, 0, 0, 2);
        add(1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // GEN
        add(0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 2, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0, 3);  // abort on the sample cycle
        add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, LEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // new_game beats submit
        add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            g = (vecs[i].gm == 2'd1) ? exp_code : (vecs[i].gm == 2'd2) ? wrong_p : vecs[i].glit;
            drive(vecs[i].ng, vecs[i].sub, g);
            #1;
            if (vecs[i].cap) capture();
            tag = $sformatf("v%0d", i);
            chk({tag, "_busy"}, busy, vecs[i].busy);
            chk({tag, "_gerr"}, guess_err, vecs[i].gerr);
            chk({tag, "_fbv"}, fb_valid, vecs[i].fbv);
            chk({tag, "_won"}, won, vecs[i].won);
            chk({tag, "_lost"}, lost, vecs[i].lost);
            chk({tag, "_last"}, last_turn, vecs[i].last);
            chk({tag, "_turn"}, turn, vecs[i].turn);
            if (vecs[i].hm != 2'd0) begin
                eh = (vecs[i].hm == 2'd2) ? exp_code : (vecs[i].hm == 2'd3) ? wrong_p : 12'h000;
                chk({tag, "_hist"}, hist_p, eh);
            end
            if (vecs[i].cc) chk({tag, "_code"}, code_p, exp_code);
        end

        // Eight wrong guesses run the game out to LOSE.
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, wrong_p);
            #1;
            chk($sformatf("b%0d_turn", t), turn, t);
            chk($sformatf("b%0d_last", t), last_turn, (t == 7) ? 1 : 0);
            chk($sformatf("b%0d_gerr", t), guess_err, 0);
            @(negedge clk);
            drive(1'b0, 1'b0, 12'h000);
            #1;
            chk($sformatf("b%0d_busy", t), busy, 1);
            chk($sformatf("b%0d_fbv0", t), fb_valid, 0);
            @(negedge clk);
            #1;
            chk($sformatf("b%0d_fbv1", t), fb_valid, 1);
            @(negedge clk);
            #1;
            if (t < 7) begin
                chk($sformatf("b%0d_next_turn", t), turn, t + 1);
                chk($sformatf("b%0d_not_lost", t), lost, 0);
                chk($sformatf("b%0d_idle", t), busy, 0);
            end else begin
                chk("lose_lost", lost, 1);
                chk("lose_turn", turn, 7);
                chk("lose_last", last_turn, 0);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b1, LEGAL);
        #1 chk("lose_sub_gerr", guess_err, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        #1;
        chk("lose_hold", lost, 1);
        chk("lose_hold_turn", turn, 7);
        chk("lose_hold_hist", hist_p, wrong_p);
        chk("lose_hold_code", code_p, exp_code);

        // Asynchronous reset in the middle of EVAL.
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h000);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        #1 capture();
        @(negedge clk);
        drive(1'b0, 1'b1, wrong_p);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        #1 chk("eval_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fbv", fb_valid, 0);
        chk("mid_rst_turn", turn, 0);
        chk("mid_rst_code", code_p, 0);
        chk("mid_rst_hist", hist_p, 0);
        chk("mid_rst_flags", {won, lost, last_turn, guess_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, BAD);
        #1;
        chk("post_rst_gerr", guess_err, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fbv", fb_valid, 0);
        drive(1'b0, 1'b0, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
